// File: rtl/vend_pkg.sv
// Shared vending definitions: credit width, coin denominations, payout FSM states
// and the greedy coin-selection helpers used by change_payout_ctrl.
package vend_pkg;

    localparam int CREDIT_W = 7;
    localparam int HOP_W    = 4;

    localparam logic [CREDIT_W-1:0] DENOM_1  = 7'd1;
    localparam logic [CREDIT_W-1:0] DENOM_5  = 7'd5;
    localparam logic [CREDIT_W-1:0] DENOM_10 = 7'd10;
    localparam logic [CREDIT_W-1:0] DENOM_20 = 7'd20;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        REQ,
        WAIT_REL,
        DONE,
        FAULT
    } payout_state_t;

    // Largest coin that still fits in the remaining amount, as a one-hot hopper select.
    function automatic logic [HOP_W-1:0] pick_coin(input logic [CREDIT_W-1:0] amt);
        logic [HOP_W-1:0] sel;
        sel = '0;
        if (amt >= DENOM_20) begin
            sel = 4'b1000;
        end else if (amt >= DENOM_10) begin
            sel = 4'b0100;
        end else if (amt >= DENOM_5) begin
            sel = 4'b0010;
        end else if (amt >= DENOM_1) begin
            sel = 4'b0001;
        end
        return sel;
    endfunction

    function automatic logic [CREDIT_W-1:0] coin_value(input logic [HOP_W-1:0] sel);
        logic [CREDIT_W-1:0] val;
        case (sel)
            4'b0001: val = DENOM_1;
            4'b0010: val = DENOM_5;
            4'b0100: val = DENOM_10;
            4'b1000: val = DENOM_20;
            default: val = '0;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/payout_timer.sv
// Handshake watchdog for change_payout_ctrl: counts cycles while running and
// saturates at LIMIT; a clear restarts it from zero.
module payout_timer #(
    parameter int LIMIT = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_run,
    output logic o_expired
);

    localparam int CNT_W = $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_run && (r_count != LIMIT_C)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_expired = (r_count == LIMIT_C);

endmodule

// File: rtl/change_payout_ctrl.sv
// Change payout controller: pays an amount out of 1/5/10/20 hoppers, largest coin first.
// Define CHANGE_TIMEOUT_EN to add the hopper handshake watchdog and the o_fault port.
module change_payout_ctrl
    import vend_pkg::*;
#(
    parameter int ACK_TIMEOUT = 1000,
    parameter int MAX_AMOUNT  = 99
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    input  logic [CREDIT_W-1:0] i_amount,
    input  logic [HOP_W-1:0]    i_hop_ack,
    input  logic                i_clr_fault,
    output logic [HOP_W-1:0]    o_hop_req,
    output logic                o_busy,
    output logic                o_done,
    output logic [CREDIT_W-1:0] o_paid
`ifdef CHANGE_TIMEOUT_EN
    ,
    output logic                o_fault
`endif
);

    localparam logic [CREDIT_W-1:0] MAX_C = CREDIT_W'(MAX_AMOUNT);

    payout_state_t       r_state;
    payout_state_t       w_next;
    logic [CREDIT_W-1:0] r_remaining;
    logic [CREDIT_W-1:0] r_paid;
    logic [HOP_W-1:0]    r_sel;
    logic [CREDIT_W-1:0] w_clamped;
    logic [CREDIT_W-1:0] w_coin;
    logic                w_ack_hit;
    logic                w_timeout;
    logic                w_clr_fault;

    assign w_clamped = (i_amount > MAX_C) ? MAX_C : i_amount;
    assign w_coin    = coin_value(r_sel);
    // Only the ack line of the coin currently being paid matters; others are noise.
    assign w_ack_hit = |(i_hop_ack & r_sel);

`ifdef CHANGE_TIMEOUT_EN
    payout_timer #(
        .LIMIT(ACK_TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_next != r_state),
        .i_run    ((r_state == REQ) || (r_state == WAIT_REL)),
        .o_expired(w_timeout)
    );
    assign w_clr_fault = i_clr_fault;
    assign o_fault     = (r_state == FAULT);
`else
    logic w_unused;
    assign w_timeout   = 1'b0;
    assign w_clr_fault = 1'b0;
    assign w_unused    = i_clr_fault ^ (ACK_TIMEOUT == 0);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_next = (w_clamped == '0) ? DONE : SELECT;
                end
            end
            SELECT: w_next = REQ;
            REQ: begin
                if (w_ack_hit) begin
                    w_next = WAIT_REL;
                end else if (w_timeout) begin
                    w_next = FAULT;
                end
            end
            WAIT_REL: begin
                if (!w_ack_hit) begin
                    w_next = (r_remaining == '0) ? DONE : SELECT;
                end else if (w_timeout) begin
                    w_next = FAULT;
                end
            end
            DONE: w_next = IDLE;
            FAULT: begin
                if (w_clr_fault) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Amount bookkeeping; paid is deliberately left untouched outside an accepted start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_remaining <= '0;
            r_paid      <= '0;
            r_sel       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_remaining <= w_clamped;
                        r_paid      <= '0;
                    end
                end
                SELECT: r_sel <= pick_coin(r_remaining);
                REQ: begin
                    if (w_ack_hit) begin
                        r_remaining <= r_remaining - w_coin;
                        r_paid      <= r_paid + w_coin;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_hop_req = (r_state == REQ) ? r_sel : '0;
    assign o_busy    = (r_state != IDLE);
    assign o_done    = (r_state == DONE);
    assign o_paid    = r_paid;

endmodule

// File: tb/tb_change_payout_ctrl.sv
// Self-checking bench for change_payout_ctrl: table vectors, random amounts against a
// greedy-change model, plus ignored-start, reset-abort and (with CHANGE_TIMEOUT_EN) timeout cases.
module tb_change_payout_ctrl;

    typedef struct {
        int amount;
        int expPaid;
        int expCoins;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_start;
    logic [6:0] i_amount;
    logic [3:0] i_hop_ack = 4'b0;
    logic       i_clr_fault;
    logic [3:0] o_hop_req;
    logic       o_busy;
    logic       o_done;
    logic [6:0] o_paid;
`ifdef CHANGE_TIMEOUT_EN
    logic       o_fault;
`endif

    int   total = 0;
    int   bad = 0;
    int   coinQ[$];
    int   expQ[$];
    int   doneCount = 0;
    int   protoErrors = 0;
    bit   hopperEnable = 1'b1;
    logic [3:0] ackBit = 4'b0;
    int   hopWait = 0;

    always #5 clk = ~clk;

    change_payout_ctrl #(
        .ACK_TIMEOUT(1000),
        .MAX_AMOUNT (99)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_start    (i_start),
        .i_amount   (i_amount),
        .i_hop_ack  (i_hop_ack),
        .i_clr_fault(i_clr_fault),
        .o_hop_req  (o_hop_req),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_paid     (o_paid)
`ifdef CHANGE_TIMEOUT_EN
        ,
        .o_fault    (o_fault)
`endif
    );

    function automatic int denomOf(input logic [3:0] sel);
        case (sel)
            4'b0001: return 1;
            4'b0010: return 5;
            4'b0100: return 10;
            4'b1000: return 20;
            default: return 0;
        endcase
    endfunction

    // Hopper model: acks each request after a random delay, records the coin, releases
    // after the request drops, and wiggles unrelated ack lines as noise.
    always @(negedge clk) begin : hopper
        logic [3:0] noise;
        if (!$onehot0(o_hop_req)) protoErrors++;
        if ((o_hop_req != 4'b0) && (ackBit != 4'b0) && (o_hop_req != ackBit)) protoErrors++;
        if (!hopperEnable) begin
            ackBit  = 4'b0;
            hopWait = 0;
        end else if (ackBit == 4'b0) begin
            if (o_hop_req != 4'b0) begin
                if (hopWait == 0) begin
                    ackBit = o_hop_req;
                    coinQ.push_back(denomOf(o_hop_req));
                    hopWait = int'($urandom_range(0, 3));
                end else begin
                    hopWait--;
                end
            end
        end else if (o_hop_req == 4'b0) begin
            if (hopWait == 0) begin
                ackBit  = 4'b0;
                hopWait = int'($urandom_range(0, 3));
            end else begin
                hopWait--;
            end
        end
        noise = ((o_hop_req != 4'b0) && hopperEnable) ? (4'($urandom()) & ~o_hop_req) : 4'b0;
        i_hop_ack = ackBit | noise;
    end

    always @(posedge clk) begin
        if (o_done) doneCount++;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
        end
    endtask

    // Greedy change from plain arithmetic: biggest coin first, amount clamped to 99.
    task automatic modelPayout(input int amt, output int expPaid);
        int rem;
        int coins[4] = '{20, 10, 5, 1};
        rem = (amt > 99) ? 99 : amt;
        expPaid = rem;
        expQ.delete();
        foreach (coins[k]) begin
            while (rem >= coins[k]) begin
                expQ.push_back(coins[k]);
                rem -= coins[k];
            end
        end
    endtask

    task automatic checkSequence(input string name, input int base);
        int n;
        bit ok;
        n  = coinQ.size() - base;
        ok = (n == expQ.size());
        for (int i = 0; i < n && ok; i++) begin
            if (coinQ[base + i] != expQ[i]) ok = 1'b0;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("[TB] FAIL %s: coin sequence differs, got %0d coins, want %0d coins", name, n, expQ.size());
        end
    endtask

    task automatic applyStimulus(input int amt, input bit junk, input int expPaid,
                                 input int expCoins, input string tag);
        int base;
        int doneBase;
        int modelPaid;
        bit seen;
        modelPayout(amt, modelPaid);
        base     = coinQ.size();
        doneBase = doneCount;
        @(negedge clk);
        i_start  = 1'b1;
        i_amount = 7'(amt);
        @(negedge clk);
        i_start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 3000 && !seen; c++) begin
            if (o_done) begin
                seen = 1'b1;
            end else begin
                i_start  = junk && ((c % 4) == 1);
                i_amount = 7'd5;
                @(negedge clk);
            end
        end
        i_start = 1'b0;
        checkOutput({tag, ".doneSeen"}, int'(seen), 1);
        @(negedge clk);
        @(negedge clk);
        checkOutput({tag, ".paid"}, int'(o_paid), expPaid);
        checkOutput({tag, ".coins"}, coinQ.size() - base, expCoins);
        checkSequence({tag, ".seq"}, base);
        checkOutput({tag, ".donePulses"}, doneCount - doneBase, 1);
        checkOutput({tag, ".idle"}, int'(o_busy), 0);
    endtask

    initial begin
        vec_t vecs[11];
        int   base;
        int   doneBase;
        int   p;
        bit   found;

        vecs[0]  = '{37, 37, 5};
        vecs[1]  = '{0, 0, 0};
        vecs[2]  = '{120, 99, 10};
        vecs[3]  = '{99, 99, 10};
        vecs[4]  = '{1, 1, 1};
        vecs[5]  = '{4, 4, 4};
        vecs[6]  = '{25, 25, 2};
        vecs[7]  = '{127, 99, 10};
        vecs[8]  = '{19, 19, 6};
        vecs[9]  = '{64, 64, 7};
        vecs[10] = '{16, 16, 3};

        rst         = 1'b1;
        i_start     = 1'b0;
        i_amount    = 7'd0;
        i_clr_fault = 1'b0;
        #1 rst = 1'b0;
        #2;
        checkOutput("reset.busy", int'(o_busy), 0);
        checkOutput("reset.done", int'(o_done), 0);
        checkOutput("reset.paid", int'(o_paid), 0);
        checkOutput("reset.hopReq", int'(o_hop_req), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].amount, 1'b0, vecs[i].expPaid, vecs[i].expCoins,
                          $sformatf("vec%0d_amt%0d", i, vecs[i].amount));
        end

        repeat (5) @(negedge clk);
        checkOutput("paidHoldInIdle", int'(o_paid), 16);

        // Zero amount: done one cycle after the sampling edge, idle the cycle after.
        base     = coinQ.size();
        doneBase = doneCount;
        @(negedge clk);
        i_start  = 1'b1;
        i_amount = 7'd0;
        @(negedge clk);
        i_start = 1'b0;
        checkOutput("zero.doneAtN1", int'(o_done), 1);
        checkOutput("zero.busyAtN1", int'(o_busy), 1);
        @(negedge clk);
        checkOutput("zero.doneGoneAtN2", int'(o_done), 0);
        checkOutput("zero.idleAtN2", int'(o_busy), 0);
        checkOutput("zero.paid", int'(o_paid), 0);
        checkOutput("zero.noCoins", coinQ.size() - base, 0);
        checkOutput("zero.donePulses", doneCount - doneBase, 1);

        applyStimulus(37, 1'b1, 37, 5, "ignoreStart");

        for (int i = 0; i < 25; i++) begin
            int a;
            a = int'($urandom_range(0, 127));
            modelPayout(a, p);
            applyStimulus(a, 1'b0, p, expQ.size(), $sformatf("rand%0d_amt%0d", i, a));
        end

        // Reset while the hopper is still holding its ack for the first coin.
        doneBase = doneCount;
        @(negedge clk);
        i_start  = 1'b1;
        i_amount = 7'd37;
        @(negedge clk);
        i_start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            if (o_busy && (o_hop_req == 4'b0) && (i_hop_ack != 4'b0)) found = 1'b1;
            else @(negedge clk);
        end
        checkOutput("rstAbort.reachedWaitRel", int'(found), 1);
        #2 rst = 1'b0;
        #1;
        checkOutput("rstAbort.busy", int'(o_busy), 0);
        checkOutput("rstAbort.done", int'(o_done), 0);
        checkOutput("rstAbort.paid", int'(o_paid), 0);
        checkOutput("rstAbort.hopReq", int'(o_hop_req), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (15) @(negedge clk);
        checkOutput("rstAbort.noDone", doneCount - doneBase, 0);
        checkOutput("rstAbort.stillIdle", int'(o_busy), 0);

`ifdef CHANGE_TIMEOUT_EN
        begin
            int cnt;
            bit faultSeen;
            base = coinQ.size();
            @(negedge clk);
            i_start  = 1'b1;
            i_amount = 7'd37;
            @(negedge clk);
            i_start = 1'b0;
            for (int c = 0; c < 300 && coinQ.size() < base + 2; c++) @(negedge clk);
            checkOutput("timeout.twoCoinsPaid", coinQ.size() - base, 2);
            hopperEnable = 1'b0;
            @(negedge clk);
            cnt = 0;
            faultSeen = 1'b0;
            for (int c = 0; c < 3000 && !faultSeen; c++) begin
                if (o_fault) begin
                    faultSeen = 1'b1;
                end else begin
                    if (o_hop_req != 4'b0) cnt++;
                    @(negedge clk);
                end
            end
            checkOutput("timeout.faultSeen", int'(faultSeen), 1);
            total++;
            if (cnt < 1000 || cnt > 1001) begin
                bad++;
                $display("[TB] FAIL timeout.reqCycles: got %0d, want 1000..1001", cnt);
            end
            checkOutput("timeout.hopReqLow", int'(o_hop_req), 0);
            checkOutput("timeout.busy", int'(o_busy), 1);
            repeat (3) @(negedge clk);
            checkOutput("timeout.faultHeld", int'(o_fault), 1);
            i_clr_fault = 1'b1;
            @(negedge clk);
            i_clr_fault = 1'b0;
            checkOutput("timeout.faultCleared", int'(o_fault), 0);
            checkOutput("timeout.idleAfterClr", int'(o_busy), 0);
            checkOutput("timeout.paidRetained", int'(o_paid), 30);
            hopperEnable = 1'b1;
            repeat (5) @(negedge clk);
        end
`endif

        checkOutput("protocol.violations", protoErrors, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
